// File: rtl/cpu6_bus_pkg.sv
// CPU6 bus controller shared types and constants.
// Used by cpu6_bus_ctrl and cpu6_page_table; CPU6_MMU_EN selects the page-table build.
package cpu6_bus_pkg;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, IOWAIT, DONE} state_t;
    typedef enum logic [1:0] {ROM, RAM, IO, PT} region_t;

    localparam logic [15:0] PT_BASE      = 16'hF100;
    localparam logic [15:0] PT_LAST      = 16'hF11F;
    localparam logic [7:0]  ERR_CLR_ADDR = 8'hFF;   // offset from IO_BASE
    localparam logic [7:0]  TIMEOUT_DATA = 8'hFF;

    // Region decode, priority ROM > I/O > page table > RAM. ROM runs up to 16'hFFFF inclusive.
    function automatic region_t decode(input logic [15:0] la, input logic [15:0] rom_base,
                                       input logic [15:0] io_base, input logic mmu_en);
        logic [16:0] io_last;
        io_last = {1'b0, io_base} + 17'h000FF;
        if (la >= rom_base)
            return ROM;
        if ({1'b0, la} >= {1'b0, io_base} && {1'b0, la} <= io_last)
            return IO;
        if (mmu_en && la >= PT_BASE && la <= PT_LAST)
            return PT;
        return RAM;
    endfunction

endpackage

// File: rtl/cpu6_page_table.sv
// 32 x 7 logical-to-physical page table for the CPU6 MMU (CPU6_MMU_EN builds only).
// Async clear, synchronous write, two combinational read ports: one for translation,
// one for CPU reads of the table itself.
import cpu6_bus_pkg::*;

module cpu6_page_table (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [4:0] wr_idx_i,
    input  logic [6:0] wr_data_i,
    input  logic [4:0] map_idx_i,
    output logic [6:0] map_o,
    input  logic [4:0] ent_idx_i,
    output logic [6:0] ent_o
);

    logic [31:0][6:0] pt_q;

    // Table storage: cleared by reset, one entry written per CPU write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pt_q <= '0;
        else if (wr_en_i)
            pt_q[wr_idx_i] <= wr_data_i;
    end

    assign map_o = pt_q[map_idx_i];
    assign ent_o = pt_q[ent_idx_i];

endmodule

// File: rtl/cpu6_bus_ctrl.sv
// CPU6 bus controller: region decode, per-region wait states, I/O ack/timeout handshake.
// Define CPU6_MMU_EN to add the 32-entry page table (writable at 16'hF100..16'hF11F) that
// translates RAM accesses to 18-bit physical addresses.
import cpu6_bus_pkg::*;

module cpu6_bus_ctrl #(
    parameter int unsigned ROM_WAIT   = 0,
    parameter int unsigned RAM_WAIT   = 1,
    parameter int unsigned IO_TIMEOUT = 15,
    parameter logic [15:0] ROM_BASE   = 16'hFC00,
    parameter logic [15:0] IO_BASE    = 16'hF000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        bus_error,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        mem_we,
    output logic        mem_oe,
    output logic        io_cs,
    input  logic        io_ack
);

`ifdef CPU6_MMU_EN
    localparam logic MMU_ON = 1'b1;
`else
    localparam logic MMU_ON = 1'b0;
`endif

    localparam logic [15:0] ERR_CLR = IO_BASE + {8'h00, ERR_CLR_ADDR};

    state_t      state_q, state_d;
    region_t     region_q, req_region;
    logic        we_q;
    logic [7:0]  wdata_q, rdata_q, cnt_q, cnt_d, wait_load;
    logic [17:0] mem_addr_q, phys_addr;
    logic        err_q, busy_q, busy_d, done_q, done_d;
    logic        rom_cs_q, rom_cs_d, ram_cs_q, ram_cs_d, io_cs_q, io_cs_d;
    logic        mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
    logic [6:0]  pt_frame, pt_entry;
    logic        req, cnt_zero;

    assign req      = cpu_we | cpu_re;
    assign cnt_zero = (cnt_q == 8'd0);

`ifdef CPU6_MMU_EN
    logic pt_we;
    assign pt_we = (state_q == WAIT) && cnt_zero && (region_q == PT) && we_q;
    // Page-table entry index is the low address bits, which PT accesses carry untranslated.
    cpu6_page_table u_pt (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (pt_we),
        .wr_idx_i  (mem_addr_q[4:0]),
        .wr_data_i (wdata_q[6:0]),
        .map_idx_i (cpu_addr[15:11]),
        .map_o     (pt_frame),
        .ent_idx_i (mem_addr_q[4:0]),
        .ent_o     (pt_entry)
    );
`else
    assign pt_frame = '0;
    assign pt_entry = '0;
`endif

    // Decode the incoming request and form its physical address; only RAM is translated.
    always_comb begin
        req_region = decode(cpu_addr, ROM_BASE, IO_BASE, MMU_ON);
        phys_addr  = {2'b00, cpu_addr};
        if (MMU_ON && req_region == RAM)
            phys_addr = {pt_frame, cpu_addr[10:0]};
    end

    // Wait-counter preload per region; I/O counts IO_TIMEOUT cycles including the last one.
    always_comb begin
        case (region_q)
            ROM:     wait_load = 8'(ROM_WAIT);
            RAM:     wait_load = 8'(RAM_WAIT);
            IO:      wait_load = 8'(IO_TIMEOUT - 1);
            default: wait_load = 8'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (req) state_d = ACCESS;
            ACCESS: begin
                cnt_d   = wait_load;
                state_d = (region_q == IO) ? IOWAIT : WAIT;
            end
            WAIT: begin
                if (cnt_zero) state_d = DONE;
                else          cnt_d   = cnt_q - 8'd1;
            end
            IOWAIT: begin
                if (io_ack || cnt_zero) state_d = DONE;
                else                    cnt_d   = cnt_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every strobe comes straight off a flop.
    always_comb begin
        logic strobe;
        strobe   = (state_d == WAIT) || (state_d == IOWAIT);
        rom_cs_d = (state_d == WAIT) && (region_q == ROM);
        ram_cs_d = (state_d == WAIT) && (region_q == RAM);
        io_cs_d  = (state_d == IOWAIT);
        mem_we_d = strobe && (region_q != PT) && we_q;
        mem_oe_d = strobe && (region_q != PT) && !we_q;
        busy_d   = (state_d == ACCESS) || strobe;
        done_d   = (state_d == DONE);
    end

    // Output registers; reset drops every select and strobe immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {rom_cs_q, ram_cs_q, io_cs_q, mem_we_q, mem_oe_q, busy_q, done_q} <= '0;
        end else begin
            rom_cs_q <= rom_cs_d;
            ram_cs_q <= ram_cs_d;
            io_cs_q  <= io_cs_d;
            mem_we_q <= mem_we_d;
            mem_oe_q <= mem_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Request latch, read-data capture and the sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            region_q   <= RAM;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == IDLE && req) begin
                region_q   <= req_region;
                we_q       <= cpu_we;
                wdata_q    <= cpu_wdata;
                mem_addr_q <= phys_addr;
                if (cpu_we && cpu_addr == ERR_CLR)
                    err_q <= 1'b0;
            end
            if (state_q == WAIT && cnt_zero && !we_q)
                rdata_q <= (region_q == PT) ? {1'b0, pt_entry} : mem_rdata;
            if (state_q == IOWAIT) begin
                if (io_ack) begin
                    if (!we_q) rdata_q <= mem_rdata;
                end else if (cnt_zero) begin
                    err_q <= 1'b1;
                    if (!we_q) rdata_q <= TIMEOUT_DATA;
                end
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign bus_error = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign rom_cs    = rom_cs_q;
    assign ram_cs    = ram_cs_q;
    assign io_cs     = io_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;

endmodule
